// File: rtl/mbist_pkg.sv
// Shared types and sizing helpers for the MBIST background generator.
// MBIST_BG_WALK_EN appends DATA_W walking-1 backgrounds.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } bg_state_t;

    localparam int MAX_W = 1024;

    function automatic int num_bg(input int w);
        int l;
        l = $clog2(w);
`ifdef MBIST_BG_WALK_EN
        return 2 * l + 2 + w;
`else
        return 2 * l + 2;
`endif
    endfunction

    function automatic int idx_w(input int w);
        return $clog2(num_bg(w));
    endfunction

    // Bit i of a stripe at a given level is bit <level> of i.
    function automatic logic [MAX_W-1:0] stripe_pattern(
        input int level,
        input int width
    );
        logic [MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                p[i] = 1'(i >> level);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mbist_bg_pattern.sv
// Combinational background index to data pattern lookup.
// MBIST_BG_WALK_EN adds the walking-1 branch after the solids.
module mbist_bg_pattern
    import mbist_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int IDX_W  = idx_w(DATA_W)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] pattern
);

    localparam int L = $clog2(DATA_W);

    localparam logic [IDX_W-1:0] ZERO_IDX = IDX_W'(2 * L);
    localparam logic [IDX_W-1:0] ONES_IDX = IDX_W'(2 * L + 1);
`ifdef MBIST_BG_WALK_EN
    localparam logic [IDX_W-1:0] WALK_IDX = IDX_W'(2 * L + 2);
`endif

    logic [DATA_W-1:0] stripe;

    always_comb begin
        stripe  = DATA_W'(stripe_pattern(int'(idx >> 1), DATA_W));
        pattern = '0;
        unique case (1'b1)
            (idx < ZERO_IDX):
                pattern = stripe ^ {DATA_W{idx[0]}};
            (idx == ZERO_IDX):
                pattern = '0;
            (idx == ONES_IDX):
                pattern = '1;
`ifdef MBIST_BG_WALK_EN
            (idx > ONES_IDX):
                pattern = DATA_W'(1) << (idx - WALK_IDX);
`endif
            default:
                pattern = '0;
        endcase
    end

endmodule

// File: rtl/mbist_bg_gen.sv
// Sequential MBIST data-background generator with start/next/abort control.
// MBIST_BG_WALK_EN enables the walking-1 backgrounds.
module mbist_bg_gen
    import mbist_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int IDX_W  = idx_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              next,
    input  logic              abort,
    input  logic              inv,
    output logic [IDX_W-1:0]  bg_idx,
    output logic [DATA_W-1:0] data_t,
    output logic              bg_valid,
    output logic              busy,
    output logic              last,
    output logic              done
);

    localparam int NUM_BG = num_bg(DATA_W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BG - 1);

    bg_state_t         state;
    bg_state_t         state_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic [DATA_W-1:0] pat_nx;
    logic [DATA_W-1:0] data_nx;
    logic              valid_nx;
    logic              last_nx;
    logic              done_nx;

    mbist_bg_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .idx     (idx_nx),
        .pattern (pat_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bg_idx   <= '0;
            data_t   <= '0;
            bg_valid <= 1'b0;
            busy     <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            bg_idx   <= idx_nx;
            data_t   <= data_nx;
            bg_valid <= valid_nx;
            busy     <= valid_nx;
            last     <= last_nx;
            done     <= done_nx;
        end
    end

    // Index follows the state: zero on entry, held in DONE at the last index.
    always_comb begin
        state_nx = state;
        idx_nx   = '0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_nx = ACTIVE;
                    end
                end
                ACTIVE: begin
                    idx_nx = bg_idx;
                    if (next && bg_idx == LAST_IDX) begin
                        state_nx = DONE;
                    end else if (next) begin
                        idx_nx = bg_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    idx_nx = LAST_IDX;
                    if (start) begin
                        state_nx = ACTIVE;
                        idx_nx   = '0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_nx  = '0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        done_nx  = 1'b0;
        unique case (state_nx)
            ACTIVE: begin
                data_nx  = pat_nx ^ {DATA_W{inv}};
                valid_nx = 1'b1;
                last_nx  = (idx_nx == LAST_IDX);
            end
            DONE: begin
                done_nx = 1'b1;
            end
            default: begin
                data_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mbist_bg_gen.sv
// Bench for mbist_bg_gen at DATA_W=8 and DATA_W=16.
// Vector table, directed corner sequences and a random run against a model.
module tb_mbist_bg_gen;

    function automatic int nbg(input int w);
        int l;
        l = $clog2(w);
`ifdef MBIST_BG_WALK_EN
        return 2 * l + 2 + w;
`else
        return 2 * l + 2;
`endif
    endfunction

    localparam int I8  = $clog2(nbg(8));
    localparam int I16 = $clog2(nbg(16));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic next = 1'b0;
    logic abort = 1'b0;
    logic inv = 1'b0;

    logic [I8-1:0]  idx8;
    logic [7:0]     d8;
    logic           v8, b8, l8, dn8;
    logic [I16-1:0] idx16;
    logic [15:0]    d16;
    logic           v16, b16, l16, dn16;

    int n_tests = 0;
    int n_fail = 0;

    int st[2];
    int ix[2];
    int wd[2];
    logic minv;

    always #5 clk = ~clk;

    mbist_bg_gen #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .next(next),
        .abort(abort), .inv(inv), .bg_idx(idx8), .data_t(d8),
        .bg_valid(v8), .busy(b8), .last(l8), .done(dn8)
    );

    mbist_bg_gen #(.DATA_W(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .next(next),
        .abort(abort), .inv(inv), .bg_idx(idx16), .data_t(d16),
        .bg_valid(v16), .busy(b16), .last(l16), .done(dn16)
    );

    // Backgrounds from their definitions: stripes of 2^s-bit runs, solids, walks.
    function automatic logic [15:0] ref_pat(input int idx, input int w);
        int l;
        logic [15:0] p;
        l = $clog2(w);
        p = '0;
        if (idx < 2 * l) begin
            for (int i = 0; i < w; i++) begin
                p[i] = (((i / (1 << (idx / 2))) % 2) == 1) != ((idx % 2) == 1);
            end
        end else if (idx == 2 * l + 1) begin
            for (int i = 0; i < w; i++) p[i] = 1'b1;
        end else if (idx >= 2 * l + 2) begin
            p[idx - 2 * l - 2] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [15:0] exp_data(input int k);
        logic [15:0] m;
        m = '0;
        if (st[k] != 1) return 16'h0;
        if (minv) for (int i = 0; i < wd[k]; i++) m[i] = 1'b1;
        return ref_pat(ix[k], wd[k]) ^ m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic s, input logic n, input logic a);
        for (int k = 0; k < 2; k++) begin
            if (a) begin
                st[k] = 0;
                ix[k] = 0;
            end else if (st[k] == 1) begin
                if (n && ix[k] == nbg(wd[k]) - 1) st[k] = 2;
                else if (n) ix[k]++;
            end else if (s) begin
                st[k] = 1;
                ix[k] = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int e_idx[2];
        logic e_last[2];
        for (int k = 0; k < 2; k++) begin
            e_idx[k] = (st[k] == 0) ? 0 : ix[k];
            e_last[k] = (st[k] == 1) && (ix[k] == nbg(wd[k]) - 1);
        end
        chk({tag, " w8 idx"}, 32'(idx8), 32'(e_idx[0]));
        chk({tag, " w8 data"}, 32'(d8), 32'(exp_data(0)));
        chk({tag, " w8 valid"}, 32'(v8), 32'(st[0] == 1));
        chk({tag, " w8 busy"}, 32'(b8), 32'(st[0] == 1));
        chk({tag, " w8 last"}, 32'(l8), 32'(e_last[0]));
        chk({tag, " w8 done"}, 32'(dn8), 32'(st[0] == 2));
        chk({tag, " w16 idx"}, 32'(idx16), 32'(e_idx[1]));
        chk({tag, " w16 data"}, 32'(d16), 32'(exp_data(1)));
        chk({tag, " w16 valid"}, 32'(v16), 32'(st[1] == 1));
        chk({tag, " w16 busy"}, 32'(b16), 32'(st[1] == 1));
        chk({tag, " w16 last"}, 32'(l16), 32'(e_last[1]));
        chk({tag, " w16 done"}, 32'(dn16), 32'(st[1] == 2));
    endtask

    task automatic tick(input string tag, input logic s, input logic n,
                        input logic a, input logic i);
        start = s;
        next  = n;
        abort = a;
        inv   = i;
        @(posedge clk);
        model_step(s, n, a);
        minv = i;
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic s, n, a, i;
        int         eidx;
        logic [7:0] edata;
        logic       evalid, edone;
    } vec_t;

    vec_t tbl[13];

    initial begin
        wd[0] = 8;
        wd[1] = 16;
        st = '{0, 0};
        ix = '{0, 0};
        minv = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 8'hAA, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 8'hAA, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h55, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 8'hCC, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h33, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 8'hCC, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 8'h33, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 8'hF0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5, 8'h0F, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 8'h0F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 13; t++) begin
            tick($sformatf("tbl%0d", t), tbl[t].s, tbl[t].n, tbl[t].a, tbl[t].i);
            chk($sformatf("tbl%0d idx", t), 32'(idx8), 32'(tbl[t].eidx));
            chk($sformatf("tbl%0d data", t), 32'(d8), 32'(tbl[t].edata));
            chk($sformatf("tbl%0d valid", t), 32'(v8), 32'(tbl[t].evalid));
            chk($sformatf("tbl%0d done", t), 32'(dn8), 32'(tbl[t].edone));
        end

        tick("run start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < nbg(16); b++) begin
            tick("run wait", 1'b0, 1'b0, 1'b0, 1'b0);
            if (b == 6) chk("w16 idx6 data", 32'(d16), 32'h0000FF00);
`ifdef MBIST_BG_WALK_EN
            if (b == 8) chk("w8 idx8 walk", 32'(d8), 32'h01);
            if (b == 15) chk("w8 idx15 walk", 32'(d8), 32'h80);
`endif
            if (b == nbg(8) - 1) chk("w8 last at end", 32'(l8), 32'h1);
            tick("run wait", 1'b0, 1'b0, 1'b0, 1'b0);
            tick("run next", 1'b0, 1'b1, 1'b0, 1'b0);
            if (b == nbg(8) - 1) begin
                chk("w8 done after run", 32'(dn8), 32'h1);
                chk("w8 valid after run", 32'(v8), 32'h0);
            end
        end
        chk("w16 done after run", 32'(dn16), 32'h1);

        tick("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart idx", 32'(idx8), 32'h0);
        chk("restart data", 32'(d8), 32'hAA);
        chk("restart done", 32'(dn8), 32'h0);

        repeat (3) tick("to idx3", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre reset idx", 32'(idx8), 32'h3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        st = '{0, 0};
        ix = '{0, 0};
        minv = 1'b0;
        check_model("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick("post rst", 1'b0, 1'b1, 1'b0, 1'b1);

        for (int r = 0; r < 3000; r++) begin
            tick("rand", ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_bg_gen.md
Name: mbist_bg_gen

Overview:
Sequential data-background generator for the MBIST engine, generalising the fixed 3-bit-to-8-bit background decoder to any power-of-two data width. It steps through a full set of stripe, solid and (optionally) walking-1 backgrounds under a start/next/abort handshake from the march controller. It applies per-element inversion and drives registered write/compare data (data_t) to the memory datapath.

Parameters:
DATA_W, 8, memory word width; power of two, >= 2
L, $clog2(DATA_W), localparam; number of stripe levels
NUM_BG, 2*L+2 (+DATA_W with walk feature), localparam; total backgrounds
IDX_W, $clog2(NUM_BG), localparam; background index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a background sequence
next  in  1  march controller finished current background; advance
abort  in  1  terminate sequence, return to idle
inv  in  1  invert current background (march element uses ~D)
bg_idx  out  IDX_W  current background index
data_t  out  DATA_W  registered background data, inversion applied
bg_valid  out  1  data_t holds a valid background
busy  out  1  sequence in progress
last  out  1  current background is index NUM_BG-1
done  out  1  sequence completed; held until next start or abort

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; bg_idx=0, data_t=0, bg_valid=0, busy=0, last=0, done=0. Reset mid-sequence aborts immediately; no state survives.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE: start -> ACTIVE, bg_idx=0. next/inv ignored.
- ACTIVE: busy=1, bg_valid=1. next with bg_idx<NUM_BG-1 -> bg_idx+1. next with bg_idx=NUM_BG-1 -> DONE. start ignored.
- DONE: done=1, busy=0, bg_valid=0, data_t=0, bg_idx holds NUM_BG-1. start -> ACTIVE at idx 0 (done clears the same edge). next ignored.
- abort in any state -> IDLE next edge; outputs return to reset values. abort wins over start/next in the same cycle.
- Latency: all outputs registered; one-cycle latency from start/next/inv sample to new bg_idx/data_t. Back-to-back next on consecutive cycles advances once per cycle.
- Pattern (bit i, i=0 LSB):
  - idx 2s (s in 0..L-1): bit i = bit s of i.
  - idx 2s+1: inverse of idx 2s.
  - idx 2L: all zeros. idx 2L+1: all ones.
  - e.g. DATA_W=8: 10101010, 01010101, 11001100, 00110011, 11110000, 00001111, 00000000, 11111111.
- data_t = pattern(bg_idx) XOR {DATA_W{inv}}, sampled each cycle in ACTIVE; toggling inv without next changes only data_t.
- last = (bg_idx==NUM_BG-1) while ACTIVE, else 0.

Optional Feature:
MBIST_BG_WALK_EN
- Defined: DATA_W walking-1 backgrounds appended after the solids. idx 2L+2+j = one-hot bit j (j=0 first). NUM_BG = 2L+2+DATA_W. inv applies (yields walking-0).
- Undefined: NUM_BG = 2L+2; walking logic absent.

Decomposition:
- Package mbist_pkg: bg_state_t enum {IDLE, ACTIVE, DONE}; function stripe_pattern(level, width); shared NUM_BG/IDX_W computation.
- Sub-module mbist_bg_pattern: combinational idx -> pattern lookup, parametrised by DATA_W, with the walk branch under the macro. Top holds the FSM, index counter and output registers.

Test Plan:
- Reset with DATA_W=8 -> all outputs 0; assert rst_n mid-ACTIVE at idx 3 -> outputs 0 asynchronously, FSM IDLE.
- start, then next every 3 cycles -> data_t sequence 10101010, 01010101, 11001100, 00110011, 11110000, 00001111, 00000000, 11111111; last=1 only at idx 7; after 8th next done=1, bg_valid=0.
- inv=1 at idx 2 -> data_t=00110011 one cycle later; inv=0 -> 11001100; bg_idx stays 2.
- abort at idx 4 together with next -> IDLE, bg_idx=0, data_t=0, done=0; subsequent next ignored.
- next in IDLE ignored; start during ACTIVE at idx 5 ignored (idx stays 5); start in DONE -> idx 0, data_t=10101010, done=0.
- MBIST_BG_WALK_EN, DATA_W=8 -> NUM_BG=16; idx 8..15 = 00000001 .. 10000000; done after 16 nexts. DATA_W=16 base run -> 10 backgrounds, idx 6 = 1111111100000000.
